// File: rtl/adder_amba_pkg.sv
// Shared definitions for the adder AXI4-Lite initiator: register map,
// bit positions, response codes, sequencer states and error codes.
package adder_amba_pkg;

  // Adder subordinate register map (byte addresses)
  localparam logic [4:0] ADDR_R0     = 5'h00;
  localparam logic [4:0] ADDR_R1     = 5'h04;
  localparam logic [4:0] ADDR_CTRL   = 5'h08;
  localparam logic [4:0] ADDR_STATUS = 5'h0C;
  localparam logic [4:0] ADDR_RESULT = 5'h10;

  // Bit positions inside CTRL and STATUS
  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_OP_BIT     = 1;
  localparam int STATUS_DONE_BIT = 0;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_A,
    ST_WR_B,
    ST_WR_CTRL,
    ST_RD_STAT,
    ST_RD_RES,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_WRESP   = 2'b01,
    ERR_RRESP   = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_t;

endpackage

// File: rtl/adder_amba_master_axi.sv
// Single-beat AXI4-Lite channel engine. A one-cycle req launches either a
// write (AW+W, then B) or a read (AR, then R); ack pulses combinationally in
// the cycle the response handshake completes, with resp/rdata valid alongside.
// All VALID/READY outputs are registers, so none depends combinationally on
// the subordinate's READY/VALID.
module axi4_lite_single_beat
  import adder_amba_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // Local request side
  input  logic                req_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic                ack_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic [1:0]          resp_o,
  // AXI4-Lite master side
  output logic [ADDR_W-1:0]   m_axi_awaddr_o,
  output logic [2:0]          m_axi_awprot_o,
  output logic                m_axi_awvalid_o,
  input  logic                m_axi_awready_i,
  output logic [DATA_W-1:0]   m_axi_wdata_o,
  output logic [DATA_W/8-1:0] m_axi_wstrb_o,
  output logic                m_axi_wvalid_o,
  input  logic                m_axi_wready_i,
  input  logic [1:0]          m_axi_bresp_i,
  input  logic                m_axi_bvalid_i,
  output logic                m_axi_bready_o,
  output logic [ADDR_W-1:0]   m_axi_araddr_o,
  output logic [2:0]          m_axi_arprot_o,
  output logic                m_axi_arvalid_o,
  input  logic                m_axi_arready_i,
  input  logic [DATA_W-1:0]   m_axi_rdata_i,
  input  logic [1:0]          m_axi_rresp_i,
  input  logic                m_axi_rvalid_i,
  output logic                m_axi_rready_o
);

  logic              awvalid_q;
  logic              wvalid_q;
  logic              bready_q;
  logic              arvalid_q;
  logic              rready_q;
  logic              wr_act_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic aw_ok;
  logic w_ok;

  // An address/data leg counts as finished once its VALID is low or is
  // being accepted this cycle; both legs finished opens the B phase.
  assign aw_ok = !awvalid_q || m_axi_awready_i;
  assign w_ok  = !wvalid_q  || m_axi_wready_i;

  // Channel handshake state; a new req is applied last so it wins over the
  // clear of the transaction that is completing on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      wr_act_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      if (awvalid_q && m_axi_awready_i) awvalid_q <= 1'b0;
      if (wvalid_q && m_axi_wready_i)   wvalid_q  <= 1'b0;
      if (wr_act_q && !bready_q && aw_ok && w_ok) bready_q <= 1'b1;
      if (bready_q && m_axi_bvalid_i) begin
        bready_q <= 1'b0;
        wr_act_q <= 1'b0;
      end
      if (arvalid_q && m_axi_arready_i) begin
        arvalid_q <= 1'b0;
        rready_q  <= 1'b1;
      end
      if (rready_q && m_axi_rvalid_i) rready_q <= 1'b0;
      if (req_i) begin
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        if (we_i) begin
          awvalid_q <= 1'b1;
          wvalid_q  <= 1'b1;
          wr_act_q  <= 1'b1;
        end else begin
          arvalid_q <= 1'b1;
        end
      end
    end
  end

  assign ack_o   = (bready_q && m_axi_bvalid_i) || (rready_q && m_axi_rvalid_i);
  assign resp_o  = bready_q ? m_axi_bresp_i : m_axi_rresp_i;
  assign rdata_o = m_axi_rdata_i;

  assign m_axi_awaddr_o  = addr_q;
  assign m_axi_awprot_o  = 3'b000;
  assign m_axi_awvalid_o = awvalid_q;
  assign m_axi_wdata_o   = wdata_q;
  assign m_axi_wstrb_o   = '1;
  assign m_axi_wvalid_o  = wvalid_q;
  assign m_axi_bready_o  = bready_q;
  assign m_axi_araddr_o  = addr_q;
  assign m_axi_arprot_o  = 3'b000;
  assign m_axi_arvalid_o = arvalid_q;
  assign m_axi_rready_o  = rready_q;

endmodule

// File: rtl/adder_amba_master.sv
// AXI4-Lite initiator for the adder accelerator: writes A, B and CTRL,
// polls STATUS until done (bounded by C_POLL_MAX reads), then reads RESULT.
module adder_amba_master
  import adder_amba_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 5,
  parameter int C_POLL_MAX         = 16
) (
  input  logic                            ACLK,
  input  logic                            ARST,
  input  logic                            i_start,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_op_a,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_op_b,
  input  logic                            i_op,
  output logic                            o_busy,
  output logic                            o_done,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   o_result,
  output logic [1:0]                      o_error,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int DW    = C_M_AXI_DATA_WIDTH;
  localparam int AW    = C_M_AXI_ADDR_WIDTH;
  localparam int CNT_W = $clog2(C_POLL_MAX + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  err_t             err_q, err_d;
  logic [DW-1:0]    result_q, result_d;
  logic [DW-1:0]    b_q, b_d;
  logic             op_q, op_d;

  logic             req;
  logic             we;
  logic [AW-1:0]    addr;
  logic [DW-1:0]    wdata;
  logic             ack;
  logic [DW-1:0]    rdata;
  logic [1:0]       resp;

  axi4_lite_single_beat #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) u_beat (
    .clk_i           (ACLK),
    .rst_i           (ARST),
    .req_i           (req),
    .we_i            (we),
    .addr_i          (addr),
    .wdata_i         (wdata),
    .ack_o           (ack),
    .rdata_o         (rdata),
    .resp_o          (resp),
    .m_axi_awaddr_o  (M_AXI_AWADDR),
    .m_axi_awprot_o  (M_AXI_AWPROT),
    .m_axi_awvalid_o (M_AXI_AWVALID),
    .m_axi_awready_i (M_AXI_AWREADY),
    .m_axi_wdata_o   (M_AXI_WDATA),
    .m_axi_wstrb_o   (M_AXI_WSTRB),
    .m_axi_wvalid_o  (M_AXI_WVALID),
    .m_axi_wready_i  (M_AXI_WREADY),
    .m_axi_bresp_i   (M_AXI_BRESP),
    .m_axi_bvalid_i  (M_AXI_BVALID),
    .m_axi_bready_o  (M_AXI_BREADY),
    .m_axi_araddr_o  (M_AXI_ARADDR),
    .m_axi_arprot_o  (M_AXI_ARPROT),
    .m_axi_arvalid_o (M_AXI_ARVALID),
    .m_axi_arready_i (M_AXI_ARREADY),
    .m_axi_rdata_i   (M_AXI_RDATA),
    .m_axi_rresp_i   (M_AXI_RRESP),
    .m_axi_rvalid_i  (M_AXI_RVALID),
    .m_axi_rready_o  (M_AXI_RREADY)
  );

  // Sequencer state, poll counter and command/result registers
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      err_q    <= ERR_OK;
      result_q <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      result_q <= result_d;
      b_q      <= b_d;
      op_q     <= op_d;
    end
  end

  // Next-state logic; each transition into a bus state issues the req for
  // that state's beat so VALID rises on the entry edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    result_d = result_q;
    b_d      = b_q;
    op_d     = op_q;
    req      = 1'b0;
    we       = 1'b0;
    addr     = ADDR_R0;
    wdata    = '0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          b_d     = i_op_b;
          op_d    = i_op;
          cnt_d   = '0;
          err_d   = ERR_OK;
          req     = 1'b1;
          we      = 1'b1;
          addr    = ADDR_R0;
          wdata   = i_op_a;
          state_d = ST_WR_A;
        end
      end
      ST_WR_A: begin
        if (ack) begin
          if (resp != RESP_OKAY) begin
            err_d   = ERR_WRESP;
            state_d = ST_DONE;
          end else begin
            req     = 1'b1;
            we      = 1'b1;
            addr    = ADDR_R1;
            wdata   = b_q;
            state_d = ST_WR_B;
          end
        end
      end
      ST_WR_B: begin
        if (ack) begin
          if (resp != RESP_OKAY) begin
            err_d   = ERR_WRESP;
            state_d = ST_DONE;
          end else begin
            req                   = 1'b1;
            we                    = 1'b1;
            addr                  = ADDR_CTRL;
            wdata[CTRL_START_BIT] = 1'b1;
            wdata[CTRL_OP_BIT]    = op_q;
            state_d               = ST_WR_CTRL;
          end
        end
      end
      ST_WR_CTRL: begin
        if (ack) begin
          if (resp != RESP_OKAY) begin
            err_d   = ERR_WRESP;
            state_d = ST_DONE;
          end else begin
            req     = 1'b1;
            addr    = ADDR_STATUS;
            state_d = ST_RD_STAT;
          end
        end
      end
      ST_RD_STAT: begin
        if (ack) begin
          if (resp != RESP_OKAY) begin
            err_d   = ERR_RRESP;
            state_d = ST_DONE;
          end else if (rdata[STATUS_DONE_BIT]) begin
            req     = 1'b1;
            addr    = ADDR_RESULT;
            state_d = ST_RD_RES;
          end else if (cnt_q == CNT_W'(C_POLL_MAX - 1)) begin
            cnt_d   = cnt_q + CNT_W'(1);
            err_d   = ERR_TIMEOUT;
            state_d = ST_DONE;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            req     = 1'b1;
            addr    = ADDR_STATUS;
          end
        end
      end
      ST_RD_RES: begin
        if (ack) begin
          if (resp != RESP_OKAY) begin
            err_d = ERR_RRESP;
          end else begin
            result_d = rdata;
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_busy   = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign o_done   = (state_q == ST_DONE);
  assign o_result = result_q;
  assign o_error  = err_q;

endmodule

// File: tb/tb_adder_amba_master.sv
module tb_adder_amba_master;

  logic        ACLK = 1'b0;
  logic        ARST;
  logic        i_start;
  logic [31:0] i_op_a, i_op_b;
  logic        i_op;
  logic        o_busy, o_done;
  logic [31:0] o_result;
  logic [1:0]  o_error;
  logic [4:0]  AWADDR, ARADDR;
  logic [2:0]  AWPROT, ARPROT;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 ACLK = ~ACLK;

  adder_amba_master dut (
    .ACLK(ACLK), .ARST(ARST), .i_start(i_start), .i_op_a(i_op_a), .i_op_b(i_op_b),
    .i_op(i_op), .o_busy(o_busy), .o_done(o_done), .o_result(o_result), .o_error(o_error),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
  );

  // Subordinate model configuration (driven only from the initial block)
  int         aw_delay = 0, w_delay = 0, ar_delay = 0, done_on = 1;
  logic       berr_en = 1'b0, rerr_en = 1'b0;
  logic [4:0] berr_addr = 5'h00;

  // Subordinate model state
  int          aw_wait, w_wait, ar_wait, wcnt, rcnt, stat_reads;
  logic        aw_got, w_got;
  logic [4:0]  awaddr_l;
  logic [31:0] wdata_l, reg_a, reg_b, reg_ctrl;
  logic [4:0]  wlog_addr [0:31];
  logic [31:0] wlog_data [0:31];
  logic [4:0]  rlog_addr [0:63];
  logic        aw_hs, w_hs, ar_hs, wr_fire;
  logic [4:0]  cur_awaddr;
  logic [31:0] cur_wdata;

  assign AWREADY    = AWVALID && (aw_wait >= aw_delay);
  assign WREADY     = WVALID && (w_wait >= w_delay);
  assign ARREADY    = ARVALID && (ar_wait >= ar_delay);
  assign aw_hs      = AWVALID && AWREADY;
  assign w_hs       = WVALID && WREADY;
  assign ar_hs      = ARVALID && ARREADY;
  assign cur_awaddr = aw_hs ? AWADDR : awaddr_l;
  assign cur_wdata  = w_hs ? WDATA : wdata_l;
  assign wr_fire    = (aw_got || aw_hs) && (w_got || w_hs);

  always @(posedge ACLK) begin
    if (ARST) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
      wcnt <= 0; rcnt <= 0; stat_reads <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; awaddr_l <= '0; wdata_l <= '0;
      BVALID <= 1'b0; BRESP <= 2'b00; RVALID <= 1'b0; RRESP <= 2'b00; RDATA <= '0;
      reg_a <= '0; reg_b <= '0; reg_ctrl <= '0;
    end else begin
      aw_wait <= (AWVALID && !AWREADY) ? aw_wait + 1 : 0;
      w_wait  <= (WVALID && !WREADY) ? w_wait + 1 : 0;
      ar_wait <= (ARVALID && !ARREADY) ? ar_wait + 1 : 0;
      if (BVALID && BREADY) BVALID <= 1'b0;
      if (wr_fire) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        BVALID <= 1'b1;
        BRESP  <= (berr_en && cur_awaddr == berr_addr) ? 2'b10 : 2'b00;
        if (wcnt < 32) begin
          wlog_addr[wcnt] <= cur_awaddr;
          wlog_data[wcnt] <= cur_wdata;
        end
        wcnt <= wcnt + 1;
        case (cur_awaddr)
          5'h00: reg_a <= cur_wdata;
          5'h04: reg_b <= cur_wdata;
          5'h08: reg_ctrl <= cur_wdata;
          default: ;
        endcase
      end else begin
        if (aw_hs) begin aw_got <= 1'b1; awaddr_l <= AWADDR; end
        if (w_hs)  begin w_got <= 1'b1;  wdata_l <= WDATA;   end
      end
      if (RVALID && RREADY) RVALID <= 1'b0;
      if (ar_hs) begin
        RVALID <= 1'b1;
        if (rcnt < 64) rlog_addr[rcnt] <= ARADDR;
        rcnt <= rcnt + 1;
        if (ARADDR == 5'h0C) begin
          stat_reads <= stat_reads + 1;
          RDATA <= (done_on != 0 && stat_reads + 1 >= done_on) ? 32'd1 : 32'd0;
          RRESP <= 2'b00;
        end else if (ARADDR == 5'h10) begin
          RDATA <= reg_ctrl[1] ? reg_a - reg_b : reg_a + reg_b;
          RRESP <= rerr_en ? 2'b10 : 2'b00;
        end else begin
          RDATA <= '0;
          RRESP <= 2'b00;
        end
      end
    end
  end

  // Protocol monitor: addr/data stable while VALID waits, VALID low right after its handshake
  int          mon_err = 0;
  logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [4:0]  p_awaddr, p_araddr;
  logic [31:0] p_wdata;
  always @(posedge ACLK) begin
    if (ARST) begin
      p_awv <= 1'b0; p_awr <= 1'b0; p_wv <= 1'b0; p_wr <= 1'b0; p_arv <= 1'b0; p_arr <= 1'b0;
    end else begin
      if (p_awv && !p_awr && !(AWVALID && AWADDR == p_awaddr)) mon_err <= mon_err + 1;
      if (p_awv && p_awr && AWVALID) mon_err <= mon_err + 1;
      if (p_wv && !p_wr && !(WVALID && WDATA == p_wdata)) mon_err <= mon_err + 1;
      if (p_wv && p_wr && WVALID) mon_err <= mon_err + 1;
      if (p_arv && !p_arr && !(ARVALID && ARADDR == p_araddr)) mon_err <= mon_err + 1;
      if (p_arv && p_arr && ARVALID) mon_err <= mon_err + 1;
      p_awv <= AWVALID; p_awr <= AWREADY; p_awaddr <= AWADDR;
      p_wv <= WVALID; p_wr <= WREADY; p_wdata <= WDATA;
      p_arv <= ARVALID; p_arr <= ARREADY; p_araddr <= ARADDR;
    end
  end

  task automatic do_reset();
    ARST = 1'b1; i_start = 1'b0; i_op_a = '0; i_op_b = '0; i_op = 1'b0;
    repeat (2) @(negedge ACLK);
    ARST = 1'b0;
  endtask

  task automatic run_cmd(input logic [31:0] a, input logic [31:0] b, input logic op,
                         output int cyc, output logic ok, output logic busy1);
    @(negedge ACLK);
    i_op_a = a; i_op_b = b; i_op = op; i_start = 1'b1;
    cyc = 0; ok = 1'b0; busy1 = 1'b0;
    while (!ok && cyc < 400) begin
      @(negedge ACLK);
      cyc++;
      if (cyc == 1) begin
        i_start = 1'b0;
        busy1 = o_busy;
      end
      if (o_done) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({o_busy, o_done, o_error, o_result} !== 36'h0) begin
      tests_failed++; $display("FAIL reset_outputs: got busy=%b done=%b err=%b res=%h, want all 0", o_busy, o_done, o_error, o_result);
    end
    tests_run++;
    if ({AWVALID, WVALID, BREADY, ARVALID, RREADY} !== 5'b0) begin
      tests_failed++; $display("FAIL reset_handshake: got aw=%b w=%b b=%b ar=%b r=%b, want 0", AWVALID, WVALID, BREADY, ARVALID, RREADY);
    end
    tests_run++;
    if ({AWADDR, ARADDR, WDATA} !== 42'h0) begin
      tests_failed++; $display("FAIL reset_addr_data: got awaddr=%h araddr=%h wdata=%h, want 0", AWADDR, ARADDR, WDATA);
    end
  endtask

  task automatic test_basic();
    int cyc; logic ok, busy1;
    do_reset();
    aw_delay = 0; w_delay = 0; ar_delay = 0; done_on = 1;
    run_cmd(32'd5, 32'd7, 1'b0, cyc, ok, busy1);
    tests_run++;
    if (!ok || cyc != 11) begin
      tests_failed++; $display("FAIL basic_latency: got done=%b after %0d cycles, want done after 11", ok, cyc);
    end
    tests_run++;
    if (busy1 !== 1'b1) begin
      tests_failed++; $display("FAIL basic_busy: got o_busy=%b in first cycle, want 1", busy1);
    end
    tests_run++;
    if (o_result !== 32'd12 || o_error !== 2'b00 || o_busy !== 1'b0) begin
      tests_failed++; $display("FAIL basic_result: got res=%0d err=%b busy=%b, want 12 00 0", o_result, o_error, o_busy);
    end
    tests_run++;
    if (wcnt != 3 || wlog_addr[0] !== 5'h00 || wlog_data[0] !== 32'd5 || wlog_addr[1] !== 5'h04 ||
        wlog_data[1] !== 32'd7 || wlog_addr[2] !== 5'h08 || wlog_data[2] !== 32'd1) begin
      tests_failed++; $display("FAIL basic_writes: got n=%0d %h=%h %h=%h %h=%h, want 3 00=5 04=7 08=1",
        wcnt, wlog_addr[0], wlog_data[0], wlog_addr[1], wlog_data[1], wlog_addr[2], wlog_data[2]);
    end
    tests_run++;
    if (rcnt != 2 || rlog_addr[0] !== 5'h0C || rlog_addr[1] !== 5'h10) begin
      tests_failed++; $display("FAIL basic_reads: got n=%0d %h %h, want 2 0c 10", rcnt, rlog_addr[0], rlog_addr[1]);
    end
    tests_run++;
    if (WSTRB !== 4'hF || AWPROT !== 3'b000 || ARPROT !== 3'b000) begin
      tests_failed++; $display("FAIL const_outputs: got wstrb=%h awprot=%b arprot=%b, want f 000 000", WSTRB, AWPROT, ARPROT);
    end
    @(negedge ACLK);
    tests_run++;
    if (o_done !== 1'b0) begin
      tests_failed++; $display("FAIL done_pulse: got o_done=%b one cycle later, want 0", o_done);
    end
  endtask

  task automatic test_handshake_order();
    int cyc; logic ok, busy1; int m0;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      m0 = mon_err;
      aw_delay = (k == 0) ? 3 : 0;
      w_delay  = (k == 0) ? 0 : 3;
      run_cmd(32'd20 + k, 32'd22, 1'b0, cyc, ok, busy1);
      tests_run++;
      if (!ok || o_result !== 32'd42 + k || o_error !== 2'b00) begin
        tests_failed++; $display("FAIL hs_result[%0d]: got done=%b res=%0d err=%b, want 1 %0d 00", k, ok, o_result, o_error, 42 + k);
      end
      tests_run++;
      if (mon_err != m0) begin
        tests_failed++; $display("FAIL hs_protocol[%0d]: got %0d violations, want 0", k, mon_err - m0);
      end
      tests_run++;
      if (wcnt != 3 || wlog_data[1] !== 32'd22 || wlog_addr[2] !== 5'h08) begin
        tests_failed++; $display("FAIL hs_writes[%0d]: got n=%0d b=%0d ctrl_addr=%h, want 3 22 08", k, wcnt, wlog_data[1], wlog_addr[2]);
      end
    end
    aw_delay = 0; w_delay = 0;
  endtask

  task automatic test_poll();
    int cyc; logic ok, busy1;
    do_reset();
    done_on = 4;
    run_cmd(32'hFFFF_FFFF, 32'd1, 1'b0, cyc, ok, busy1);
    tests_run++;
    if (!ok || cyc != 17 || stat_reads != 4) begin
      tests_failed++; $display("FAIL poll_count: got done=%b cyc=%0d status_reads=%0d, want 1 17 4", ok, cyc, stat_reads);
    end
    tests_run++;
    if (o_result !== 32'h0 || o_error !== 2'b00 || rcnt != 5 || rlog_addr[4] !== 5'h10) begin
      tests_failed++; $display("FAIL poll_result: got res=%h err=%b reads=%0d last=%h, want 0 00 5 10", o_result, o_error, rcnt, rlog_addr[4]);
    end
    done_on = 1;
  endtask

  task automatic test_timeout();
    int cyc; logic ok, busy1;
    do_reset();
    done_on = 0;
    run_cmd(32'd1, 32'd2, 1'b0, cyc, ok, busy1);
    tests_run++;
    if (!ok || cyc != 39 || o_error !== 2'b11) begin
      tests_failed++; $display("FAIL timeout_done: got done=%b cyc=%0d err=%b, want 1 39 11", ok, cyc, o_error);
    end
    tests_run++;
    if (stat_reads != 16 || rcnt != 16) begin
      tests_failed++; $display("FAIL timeout_reads: got status=%0d total=%0d, want 16 16", stat_reads, rcnt);
    end
    done_on = 1;
  endtask

  task automatic test_resp_errors();
    int cyc; logic ok, busy1;
    do_reset();
    berr_en = 1'b1; berr_addr = 5'h04;
    run_cmd(32'd9, 32'd9, 1'b0, cyc, ok, busy1);
    tests_run++;
    if (!ok || o_error !== 2'b01 || cyc != 5) begin
      tests_failed++; $display("FAIL bresp_err: got done=%b err=%b cyc=%0d, want 1 01 5", ok, o_error, cyc);
    end
    tests_run++;
    if (wcnt != 2 || rcnt != 0) begin
      tests_failed++; $display("FAIL bresp_skip: got writes=%0d reads=%0d, want 2 0", wcnt, rcnt);
    end
    berr_en = 1'b0;
    run_cmd(32'd100, 32'd23, 1'b0, cyc, ok, busy1);
    tests_run++;
    if (!ok || o_result !== 32'd123 || o_error !== 2'b00) begin
      tests_failed++; $display("FAIL recover_ok: got done=%b res=%0d err=%b, want 1 123 00", ok, o_result, o_error);
    end
    rerr_en = 1'b1;
    run_cmd(32'd1, 32'd2, 1'b0, cyc, ok, busy1);
    tests_run++;
    if (!ok || o_error !== 2'b10 || o_result !== 32'd123) begin
      tests_failed++; $display("FAIL rresp_err: got done=%b err=%b res=%0d, want 1 10 123", ok, o_error, o_result);
    end
    rerr_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc; logic ok, busy1;
    do_reset();
    run_cmd(32'd10, 32'd3, 1'b1, cyc, ok, busy1);
    tests_run++;
    if (!ok || o_result !== 32'd7 || wlog_data[2] !== 32'd3) begin
      tests_failed++; $display("FAIL op_sub: got done=%b res=%0d ctrl=%h, want 1 7 3", ok, o_result, wlog_data[2]);
    end
    run_cmd(32'h8000_0000, 32'h8000_0001, 1'b0, cyc, ok, busy1);
    tests_run++;
    if (!ok || cyc != 11 || o_result !== 32'h1 || o_error !== 2'b00) begin
      tests_failed++; $display("FAIL b2b_second: got done=%b cyc=%0d res=%h err=%b, want 1 11 1 00", ok, cyc, o_result, o_error);
    end
  endtask

  task automatic test_reset_mid();
    int cyc; int n; logic ok, busy1, seen_done;
    do_reset();
    ar_delay = 20;
    @(negedge ACLK);
    i_op_a = 32'd1; i_op_b = 32'd1; i_op = 1'b0; i_start = 1'b1;
    @(negedge ACLK);
    i_start = 1'b0;
    n = 0;
    while (!ARVALID && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    tests_run++;
    if (ARVALID !== 1'b1) begin
      tests_failed++; $display("FAIL mid_arvalid: got ARVALID=%b after %0d cycles, want 1", ARVALID, n);
    end
    ARST = 1'b1;
    @(posedge ACLK);
    #1;
    tests_run++;
    if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, o_busy, o_done} !== 7'b0) begin
      tests_failed++; $display("FAIL mid_reset: got aw=%b w=%b b=%b ar=%b r=%b busy=%b done=%b, want 0",
        AWVALID, WVALID, BREADY, ARVALID, RREADY, o_busy, o_done);
    end
    @(negedge ACLK);
    ARST = 1'b0;
    ar_delay = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      if (o_done || o_busy) seen_done = 1'b1;
    end
    tests_run++;
    if (seen_done !== 1'b0) begin
      tests_failed++; $display("FAIL mid_no_done: got done/busy activity after reset, want none");
    end
    run_cmd(32'd3, 32'd4, 1'b0, cyc, ok, busy1);
    tests_run++;
    if (!ok || cyc != 11 || o_result !== 32'd7 || o_error !== 2'b00) begin
      tests_failed++; $display("FAIL mid_restart: got done=%b cyc=%0d res=%0d err=%b, want 1 11 7 00", ok, cyc, o_result, o_error);
    end
  endtask

  initial begin
    ARST = 1'b1; i_start = 1'b0; i_op_a = '0; i_op_b = '0; i_op = 1'b0;
    test_reset();
    test_basic();
    test_handshake_order();
    test_poll();
    test_timeout();
    test_resp_errors();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
